// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcode/funct encodings and word width for the MIPS subset.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SLL   = 6'b000000;

endpackage
`default_nettype wire

// File: rtl/alu_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mem_unit_if
// Purpose  : Operand/decode inputs and result outputs of the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mem_unit_if;
    import mips_pkg::*;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [WORD_W-1:0] rs_val;
    logic [WORD_W-1:0] rt_val;
    logic [WORD_W-1:0] imm_ext;
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] difference;
    logic [WORD_W-1:0] wb_data;
    logic              reg_write;
    logic              mem_write;
    logic              branch_taken;

    modport master (
        output opcode, funct, shamt, rs_val, rt_val, imm_ext,
        input  result, difference, wb_data, reg_write, mem_write, branch_taken
    );

    modport slave (
        input  opcode, funct, shamt, rs_val, rt_val, imm_ext,
        output result, difference, wb_data, reg_write, mem_write, branch_taken
    );

endinterface
`default_nettype wire

// File: rtl/alu_mem_unit_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Purpose  : DEPTH x 32 word memory; async clear, sync write, comb read.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_addr,
    input  wire logic [WORD_W-1:0] i_wdata,
    output logic      [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Whole array clears while reset is low, which also blocks any store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/alu_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_mem_unit
// Purpose  : Single-cycle execute/memory stage: ALU, branch compare, data mem.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mem_unit
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_mem_unit_if.slave bus
);

    logic [WORD_W-1:0] w_diff;
    logic [WORD_W-1:0] w_addr_sum;
    logic [WORD_W-1:0] w_result;
    logic [WORD_W-1:0] w_rdata;
    logic              w_reg_write;
    logic              w_mem_write;
    logic              w_branch;
    logic              w_is_lw;

    assign w_diff     = bus.rs_val - bus.rt_val;
    assign w_addr_sum = bus.rs_val + bus.imm_ext;

    always_comb begin
        w_result    = '0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_is_lw     = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                w_reg_write = 1'b1;
                case (bus.funct)
                    FN_ADD:  w_result = bus.rs_val + bus.rt_val;
                    FN_SUB:  w_result = w_diff;
                    FN_AND:  w_result = bus.rs_val & bus.rt_val;
                    FN_OR:   w_result = bus.rs_val | bus.rt_val;
                    FN_SRL:  w_result = bus.rt_val >> bus.shamt;
                    FN_SLL:  w_result = bus.rt_val << bus.shamt;
                    default: w_reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                w_result    = w_addr_sum;
                w_reg_write = 1'b1;
                w_is_lw     = 1'b1;
            end
            OP_SW: begin
                w_result    = w_addr_sum;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_result = w_diff;
                w_branch = (w_diff == '0);
            end
            OP_BNE: begin
                w_result = w_diff;
                w_branch = (w_diff != '0);
            end
            default: ;
        endcase
    end

    // Word index drops the byte offset and wraps modulo DEPTH.
    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_write),
        .i_addr  (w_result[AW+1:2]),
        .i_wdata (bus.rt_val),
        .o_rdata (w_rdata)
    );

    assign bus.result       = w_result;
    assign bus.difference   = w_diff;
    assign bus.reg_write    = w_reg_write;
    assign bus.mem_write    = w_mem_write;
    assign bus.branch_taken = w_branch;
    assign bus.wb_data      = w_is_lw     ? w_rdata  :
                              w_reg_write ? w_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mem_unit
// Purpose  : Self-checking bench for alu_mem_unit with an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mem_unit;

    typedef struct {
        string       name;
        logic        rn;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [98:0] exp;
        logic [98:0] mask;
    } step_t;

    typedef struct {
        string       name;
        logic [98:0] exp;
        logic [98:0] mask;
    } sb_t;

    localparam logic [98:0] M_ALL  = {99{1'b1}};
    localparam logic [98:0] M_NOWB = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b111};

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] BN = 6'b000101;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    sb_t  sb[$];

    alu_mem_unit_if bus ();

    alu_mem_unit #(
        .DEPTH (64),
        .AW    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected vector layout: {result, difference, wb_data, reg_write, mem_write, branch_taken}
    function automatic logic [98:0] ex(logic [31:0] r, logic [31:0] d, logic [31:0] w,
                                       logic rw, logic mw, logic bt);
        return {r, d, w, rw, mw, bt};
    endfunction

    function automatic step_t mk(string n, logic rn, logic [5:0] op, logic [5:0] fn,
                                 logic [4:0] sh, logic [31:0] rs, logic [31:0] rt,
                                 logic [31:0] imm, logic [98:0] e, logic [98:0] m);
        step_t s;
        s.name = n; s.rn = rn; s.op = op; s.fn = fn; s.sh = sh;
        s.rs = rs; s.rt = rt; s.imm = imm; s.exp = e; s.mask = m;
        return s;
    endfunction

    task automatic apply(input step_t s);
        sb_t e;
        rst_n       = s.rn;
        bus.opcode  = s.op;
        bus.funct   = s.fn;
        bus.shamt   = s.sh;
        bus.rs_val  = s.rs;
        bus.rt_val  = s.rt;
        bus.imm_ext = s.imm;
        e.name = s.name; e.exp = s.exp; e.mask = s.mask;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("rst_sll0", 0, R,  6'h00, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("rst_lw",   0, LW, 6'h00, 0, 12, 0, 0, ex(12, 12, 0, 1, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_arith_logic();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("add_wrap", 1, R, 6'b100000, 0, 32'hFFFF_FFFF, 1, 0,
                       ex(0, 32'hFFFF_FFFE, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("sub_neg", 1, R, 6'b100010, 0, 5, 7, 0,
                       ex(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0, 0), M_ALL));
        s.push_back(mk("and", 1, R, 6'b100100, 0, 32'hF0F0, 32'h0FF0, 0,
                       ex(32'h00F0, 32'hE100, 32'h00F0, 1, 0, 0), M_ALL));
        s.push_back(mk("or", 1, R, 6'b100101, 0, 32'hF0F0, 32'h0FF0, 0,
                       ex(32'hFFF0, 32'hE100, 32'hFFF0, 1, 0, 0), M_ALL));
        s.push_back(mk("sll31", 1, R, 6'b000000, 31, 0, 1, 0,
                       ex(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0), M_ALL));
        s.push_back(mk("srl31", 1, R, 6'b000010, 31, 0, 32'h8000_0000, 0,
                       ex(1, 32'h8000_0000, 1, 1, 0, 0), M_ALL));
        s.push_back(mk("bad_funct", 1, R, 6'b101010, 0, 3, 1, 0,
                       ex(0, 2, 0, 0, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_store_load();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("sw_w3", 1, SW, 0, 0, 8, 32'hDEAD_BEEF, 4,
                       ex(12, 32'h2152_4119, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("lw_w3", 1, LW, 0, 0, 12, 0, 0,
                       ex(12, 12, 32'hDEAD_BEEF, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_alias", 1, LW, 0, 0, 32'h100, 0, 32'hC,
                       ex(32'h10C, 32'h100, 32'hDEAD_BEEF, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_unalign", 1, LW, 0, 0, 32'hF, 0, 0,
                       ex(32'hF, 32'hF, 32'hDEAD_BEEF, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_negimm", 1, LW, 0, 0, 32'h14, 0, 32'hFFFF_FFF8,
                       ex(32'hC, 32'h14, 32'hDEAD_BEEF, 1, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("sw_w7", 1, SW, 0, 0, 32'h1C, 32'hAAAA_0001, 0,
                       ex(32'h1C, 32'h5556_001B, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("sw_w8", 1, SW, 0, 0, 32'h20, 32'hBBBB_0002, 0,
                       ex(32'h20, 32'h4445_001E, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("lw_w7", 1, LW, 0, 0, 32'h1C, 0, 0,
                       ex(32'h1C, 32'h1C, 32'hAAAA_0001, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_w8", 1, LW, 0, 0, 32'h20, 0, 0,
                       ex(32'h20, 32'h20, 32'hBBBB_0002, 1, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_branch_illegal();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("beq_eq", 1, BQ, 0, 0, 9, 9, 0, ex(0, 0, 0, 0, 0, 1), M_NOWB));
        s.push_back(mk("beq_ne", 1, BQ, 0, 0, 9, 8, 0, ex(1, 1, 0, 0, 0, 0), M_NOWB));
        s.push_back(mk("bne_ne", 1, BN, 0, 0, 9, 8, 0, ex(1, 1, 0, 0, 0, 1), M_NOWB));
        s.push_back(mk("bne_eq", 1, BN, 0, 0, 3, 3, 0, ex(0, 0, 0, 0, 0, 0), M_NOWB));
        s.push_back(mk("illegal", 1, 6'b111111, 6'b100000, 0, 5, 3, 7,
                       ex(0, 2, 0, 0, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_reset_mem();
        step_t s[$]; sb_t e; logic [98:0] obs;
        s.push_back(mk("sw_w5", 1, SW, 0, 0, 20, 32'h1234, 0,
                       ex(20, 32'hFFFF_EDE0, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("lw_w5", 1, LW, 0, 0, 20, 0, 0, ex(20, 20, 32'h1234, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_in_rst", 0, LW, 0, 0, 20, 0, 0, ex(20, 20, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_post_rst", 1, LW, 0, 0, 20, 0, 0, ex(20, 20, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("sw_in_rst", 0, SW, 0, 0, 20, 32'h5555, 0,
                       ex(20, 32'hFFFF_AABF, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("lw_blocked", 0, LW, 0, 0, 20, 0, 0, ex(20, 20, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("lw_blocked2", 1, LW, 0, 0, 20, 0, 0, ex(20, 20, 0, 1, 0, 0), M_ALL));
        s.push_back(mk("sw_pend_rst", 0, SW, 0, 0, 20, 32'h77, 0,
                       ex(20, 32'hFFFF_FF9D, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("sw_pend_rel", 1, SW, 0, 0, 20, 32'h77, 0,
                       ex(20, 32'hFFFF_FF9D, 0, 0, 1, 0), M_NOWB));
        s.push_back(mk("lw_pending", 1, LW, 0, 0, 20, 0, 0, ex(20, 20, 32'h77, 1, 0, 0), M_ALL));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = sb.pop_front();
            obs = {bus.result, bus.difference, bus.wb_data, bus.reg_write, bus.mem_write, bus.branch_taken};
            n_cmp++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs & e.mask, e.exp & e.mask);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.shamt = '0;
        bus.rs_val = '0; bus.rt_val = '0; bus.imm_ext = '0;
        test_reset();
        test_arith_logic();
        test_store_load();
        test_back_to_back();
        test_branch_illegal();
        test_reset_mem();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
